// File: rtl/muldiv_iter.sv
// Iterative RISC-V M-extension unit: radix-2 shift-add multiply and restoring divide
// on operand magnitudes, with a one-cycle fast path for divide-by-zero and signed overflow.
module muldiv_iter #(
    parameter int Xlen    = 32,
    parameter int WordOps = 0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      funct3_i,
    input  logic            word_i,
    input  logic [Xlen-1:0] a_i,
    input  logic [Xlen-1:0] b_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [Xlen-1:0] res_o
);

    localparam int CW = $clog2(Xlen);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e            state_q;
    logic              ready_q, valid_q;
    logic [Xlen-1:0]   res_q;
    logic [2:0]        op_q;
    logic              word_q, negRes_q;
    logic [Xlen-1:0]   accHi_q, accLo_q, opB_q;
    logic [CW-1:0]     cnt_q;

    logic [Xlen-1:0]   accHi_d, accLo_d;

    logic              isDiv, wordIn, signedA, signedB, aNeg, bNeg, negIn;
    logic              bZero, ovf, isFast;
    logic [Xlen-1:0]   opA, opB, magA, magB, minNeg, aRes, fastRes;
    logic [Xlen:0]     mulSum, divShift, divDiff;
    logic [2*Xlen-1:0] prod;
    logic [Xlen-1:0]   divVal, finalRes;
    logic [CW-1:0]     lastCnt;

    function automatic logic [Xlen-1:0] sext32(input logic [31:0] v);
        logic [Xlen-1:0] r;
        r       = {Xlen{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    function automatic logic [Xlen-1:0] zext32(input logic [31:0] v);
        logic [Xlen-1:0] r;
        r       = '0;
        r[31:0] = v;
        return r;
    endfunction

    // Request decode: operand extension, magnitudes, result sign and fast-path detection.
    always_comb begin
        isDiv   = funct3_i[2];
        wordIn  = (WordOps != 0) && word_i && ((funct3_i == 3'd0) || funct3_i[2]);
        signedA = isDiv ? !funct3_i[0] : (funct3_i != 3'd3);
        signedB = isDiv ? !funct3_i[0] : !funct3_i[1];
        opA     = a_i;
        opB     = b_i;
        aRes    = a_i;
        minNeg  = '0;
        minNeg[Xlen-1] = 1'b1;
        if (wordIn) begin
            opA    = signedA ? sext32(a_i[31:0]) : zext32(a_i[31:0]);
            opB    = signedB ? sext32(b_i[31:0]) : zext32(b_i[31:0]);
            aRes   = sext32(a_i[31:0]);
            minNeg = sext32(32'h8000_0000);
        end
        aNeg    = signedA && opA[Xlen-1];
        bNeg    = signedB && opB[Xlen-1];
        magA    = aNeg ? -opA : opA;
        magB    = bNeg ? -opB : opB;
        negIn   = (isDiv && funct3_i[1]) ? aNeg : (aNeg ^ bNeg);
        bZero   = (opB == '0);
        ovf     = isDiv && !funct3_i[0] && (opA == minNeg) && (opB == '1);
        isFast  = isDiv && (bZero || ovf);
        if (bZero) begin
            fastRes = funct3_i[1] ? aRes : '1;
        end else begin
            fastRes = funct3_i[1] ? '0 : aRes;
        end
    end

    // One iteration step plus the sign-corrected result that the last step would produce.
    always_comb begin
        mulSum   = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, opB_q} : '0);
        divShift = {accHi_q, accLo_q[Xlen-1]};
        divDiff  = divShift - {1'b0, opB_q};
        if (op_q[2]) begin
            accHi_d = divDiff[Xlen] ? divShift[Xlen-1:0] : divDiff[Xlen-1:0];
            accLo_d = {accLo_q[Xlen-2:0], !divDiff[Xlen]};
        end else begin
            accHi_d = mulSum[Xlen:1];
            accLo_d = {mulSum[0], accLo_q[Xlen-1:1]};
        end
        prod = {accHi_d, accLo_d};
        if (negRes_q) prod = -prod;
        divVal = op_q[1] ? accHi_d : accLo_d;
        if (negRes_q) divVal = -divVal;
        // A word multiply runs only 32 steps, so its product sits 32 bits higher in the accumulator.
        if (op_q[2]) begin
            finalRes = word_q ? sext32(divVal[31:0]) : divVal;
        end else if (op_q[1:0] == 2'd0) begin
            finalRes = word_q ? sext32(prod[Xlen-32 +: 32]) : prod[Xlen-1:0];
        end else begin
            finalRes = prod[2*Xlen-1:Xlen];
        end
        lastCnt = word_q ? CW'(31) : CW'(Xlen-1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            res_q    <= '0;
            op_q     <= '0;
            word_q   <= 1'b0;
            negRes_q <= 1'b0;
            accHi_q  <= '0;
            accLo_q  <= '0;
            opB_q    <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        ready_q  <= 1'b0;
                        op_q     <= funct3_i;
                        word_q   <= wordIn;
                        negRes_q <= negIn;
                        cnt_q    <= '0;
                        accHi_q  <= '0;
                        if (isFast) begin
                            state_q <= DONE;
                            valid_q <= 1'b1;
                            res_q   <= fastRes;
                        end else begin
                            state_q <= CALC;
                            // Divide left-aligns the dividend so quotient bits always come from the MSB.
                            if (isDiv) begin
                                opB_q   <= magB;
                                accLo_q <= wordIn ? (magA << 32) : magA;
                            end else begin
                                opB_q   <= magA;
                                accLo_q <= magB;
                            end
                        end
                    end
                end
                CALC: begin
                    accHi_q <= accHi_d;
                    accLo_q <= accLo_d;
                    if (cnt_q == lastCnt) begin
                        state_q <= DONE;
                        valid_q <= 1'b1;
                        res_q   <= finalRes;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o = ready_q;
    assign valid_o = valid_q;
    assign res_o   = res_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench: runs a 32-bit unit and a 64-bit unit with word ops side by side
// against hand-computed vectors and an arithmetic reference model.
module tb_muldiv_iter;

    typedef struct {
        logic [2:0]  f;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] e32;
        logic [63:0] e64;
        int          l32;
        int          l64;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstN = 1'b1;
    logic        flush = 1'b0;
    logic        validIn = 1'b0;
    logic        readyIn = 1'b1;
    logic [2:0]  funct3 = 3'd0;
    logic        word = 1'b0;
    logic [63:0] aIn = '0;
    logic [63:0] bIn = '0;
    logic        ready32, valid32, ready64, valid64;
    logic [31:0] res32;
    logic [63:0] res64;

    int testCount = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    muldiv_iter #(.Xlen(32), .WordOps(0)) dut32 (
        .clk_i(clk), .rst_ni(rstN), .flush_i(flush), .valid_i(validIn), .ready_o(ready32),
        .funct3_i(funct3), .word_i(word), .a_i(aIn[31:0]), .b_i(bIn[31:0]),
        .valid_o(valid32), .ready_i(readyIn), .res_o(res32)
    );

    muldiv_iter #(.Xlen(64), .WordOps(1)) dut64 (
        .clk_i(clk), .rst_ni(rstN), .flush_i(flush), .valid_i(validIn), .ready_o(ready64),
        .funct3_i(funct3), .word_i(word), .a_i(aIn), .b_i(bIn),
        .valid_o(valid64), .ready_i(readyIn), .res_o(res64)
    );

    // Reference: RISC-V M semantics evaluated with wide signed arithmetic.
    function automatic logic [63:0] refModel(input int xl, input logic [2:0] f, input logic w,
                                             input logic [63:0] a, input logic [63:0] b,
                                             output int lat);
        int                 n;
        bit                 wop, ovf;
        logic signed [129:0] ua, ub, sa, sb, pow, r;
        logic [63:0]        mask, out;
        wop  = (xl == 64) && w && ((f == 3'd0) || (f >= 3'd4));
        n    = wop ? 32 : xl;
        pow  = 130'sd1 << n;
        mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
        ua = '0; ua[63:0] = a & mask;
        ub = '0; ub[63:0] = b & mask;
        sa = ua[n-1] ? ua - pow : ua;
        sb = ub[n-1] ? ub - pow : ub;
        ovf = (sa == -(pow >>> 1)) && (sb == -130'sd1);
        lat = n + 1;
        case (f)
            3'd0: r = sa * sb;
            3'd1: r = (sa * sb) >>> n;
            3'd2: r = (sa * ub) >>> n;
            3'd3: r = (ua * ub) >>> n;
            3'd4: if (ub == 0) begin r = -130'sd1; lat = 1; end
                  else if (ovf) begin r = sa; lat = 1; end
                  else r = sa / sb;
            3'd5: if (ub == 0) begin r = -130'sd1; lat = 1; end
                  else r = ua / ub;
            3'd6: if (ub == 0) begin r = sa; lat = 1; end
                  else if (ovf) begin r = 130'sd0; lat = 1; end
                  else r = sa % sb;
            default: if (ub == 0) begin r = ua; lat = 1; end
                  else r = ua % ub;
        endcase
        out = r[63:0] & mask;
        if (wop) out = {{32{out[31]}}, out[31:0]};
        return out;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        testCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issues one op to both units and records each result and its latency in cycles.
    task automatic applyStimulus(input logic [2:0] f, input logic w, input logic [63:0] a,
                                 input logic [63:0] b, output logic [63:0] r32,
                                 output logic [63:0] r64, output int l32, output int l64);
        int  cyc;
        bit  got32, got64;
        @(negedge clk);
        funct3 = f; word = w; aIn = a; bIn = b; validIn = 1'b1; readyIn = 1'b1;
        @(negedge clk);
        validIn = 1'b0;
        cyc = 1; got32 = 0; got64 = 0;
        r32 = 'x; r64 = 'x; l32 = -1; l64 = -1;
        while (!(got32 && got64) && cyc < 200) begin
            if (!got32 && valid32) begin r32 = {32'h0, res32}; l32 = cyc; got32 = 1; end
            if (!got64 && valid64) begin r64 = res64; l64 = cyc; got64 = 1; end
            if (!(got32 && got64)) begin
                @(negedge clk);
                cyc++;
            end
        end
    endtask

    initial begin
        vec_t        vecs[15];
        logic [63:0] r32, r64, e32, e64, a, b;
        int          l32, l64, x32, x64, cyc;
        logic [2:0]  f;
        logic        w;
        bit          sawValid;

        vecs[0]  = '{3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFEB, 64'hFFFF_FFFF_FFFF_FFEB, 33, 65};
        vecs[1]  = '{3'd1, 1'b0, 64'h8000_0000, 64'h8000_0000, 64'h4000_0000, 64'h0, 33, 65};
        vecs[2]  = '{3'd3, 1'b0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE, 64'h0, 33, 65};
        vecs[3]  = '{3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFD, 33, 65};
        vecs[4]  = '{3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 33, 65};
        vecs[5]  = '{3'd5, 1'b0, 64'hFFFF_FFFF, 64'd16, 64'h0FFF_FFFF, 64'h0FFF_FFFF, 33, 65};
        vecs[6]  = '{3'd4, 1'b0, 64'd123, 64'd0, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1};
        vecs[7]  = '{3'd7, 1'b0, 64'd5, 64'd0, 64'd5, 64'd5, 1, 1};
        vecs[8]  = '{3'd4, 1'b0, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000, 64'hFFFF_FFFF_8000_0000, 1, 65};
        vecs[9]  = '{3'd6, 1'b0, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, 1, 65};
        vecs[10] = '{3'd4, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000, 64'hFFFF_FFFF_8000_0000, 1, 1};
        vecs[11] = '{3'd0, 1'b1, 64'h1_0000, 64'h1_0000, 64'h0, 64'h0, 33, 33};
        vecs[12] = '{3'd5, 1'b1, 64'hFFFF_FFFF_0000_0010, 64'd2, 64'd8, 64'd8, 33, 33};
        vecs[13] = '{3'd6, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 33, 33};
        vecs[14] = '{3'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, 33, 65};

        #1 rstN = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset ready32", {63'h0, ready32}, 64'd1);
        checkOutput("reset valid32", {63'h0, valid32}, 64'd0);
        checkOutput("reset res32", {32'h0, res32}, 64'd0);
        checkOutput("reset ready64", {63'h0, ready64}, 64'd1);
        checkOutput("reset valid64", {63'h0, valid64}, 64'd0);
        checkOutput("reset res64", res64, 64'd0);
        rstN = 1'b1;

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].f, vecs[i].w, vecs[i].a, vecs[i].b, r32, r64, l32, l64);
            checkOutput($sformatf("vec%0d res32", i), r32, vecs[i].e32);
            checkOutput($sformatf("vec%0d lat32", i), 64'(l32), 64'(vecs[i].l32));
            checkOutput($sformatf("vec%0d res64", i), r64, vecs[i].e64);
            checkOutput($sformatf("vec%0d lat64", i), 64'(l64), 64'(vecs[i].l64));
        end

        for (int i = 0; i < 60; i++) begin
            f = 3'($urandom_range(0, 7));
            w = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0: a = 64'hFFFF_FFFF_8000_0000;
                1: a = 64'($urandom_range(0, 100));
                2: a = -64'($urandom_range(1, 100));
                3: a = 64'h8000_0000_0000_0000;
                default: a = {$urandom, $urandom};
            endcase
            case ($urandom_range(0, 7))
                0: b = 64'h0;
                1: b = '1;
                2: b = 64'($urandom_range(1, 50));
                3: b = -64'($urandom_range(1, 50));
                4: b = 64'hFFFF_FFFF_0000_0000;
                5: b = 64'h0000_0000_FFFF_FFFF;
                default: b = {$urandom, $urandom};
            endcase
            e32 = refModel(32, f, w, a, b, x32);
            e64 = refModel(64, f, w, a, b, x64);
            applyStimulus(f, w, a, b, r32, r64, l32, l64);
            checkOutput($sformatf("rnd%0d f%0d w%0d res32", i, f, w), r32, e32);
            checkOutput($sformatf("rnd%0d f%0d w%0d lat32", i, f, w), 64'(l32), 64'(x32));
            checkOutput($sformatf("rnd%0d f%0d w%0d res64", i, f, w), r64, e64);
            checkOutput($sformatf("rnd%0d f%0d w%0d lat64", i, f, w), 64'(l64), 64'(x64));
        end

        // Consumer stalls in DONE: result must hold and no new request may be taken.
        @(negedge clk);
        funct3 = 3'd5; word = 1'b0; aIn = 64'h0000_0000_DEAD_BEEF; bIn = 64'd7;
        validIn = 1'b1; readyIn = 1'b0;
        e32 = refModel(32, 3'd5, 1'b0, aIn, bIn, x32);
        e64 = refModel(64, 3'd5, 1'b0, aIn, bIn, x64);
        @(negedge clk);
        validIn = 1'b0;
        cyc = 0;
        while (!valid64 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("stall reached DONE", {63'h0, valid64}, 64'd1);
        for (int k = 0; k < 10; k++) begin
            checkOutput($sformatf("stall%0d res64", k), res64, e64);
            checkOutput($sformatf("stall%0d res32", k), {32'h0, res32}, e32);
            checkOutput($sformatf("stall%0d rdy/vld", k), {60'h0, ready64, valid64, ready32, valid32}, 64'b0101);
            @(negedge clk);
        end

        // Release together with a new request: the request waits one cycle.
        readyIn = 1'b1; validIn = 1'b1; funct3 = 3'd0; aIn = 64'd3; bIn = 64'd5;
        @(negedge clk);
        checkOutput("release idle rdy/vld", {60'h0, ready64, valid64, ready32, valid32}, 64'b1010);
        @(negedge clk);
        validIn = 1'b0;
        checkOutput("accept after release", {62'h0, ready64, ready32}, 64'b00);

        // Flush mid-calculation: back to IDLE and nothing ever comes out.
        repeat (3) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush rdy/vld", {60'h0, ready64, valid64, ready32, valid32}, 64'b1010);
        sawValid = 0;
        for (int k = 0; k < 80; k++) begin
            if (valid32 || valid64) sawValid = 1;
            @(negedge clk);
        end
        checkOutput("flush no result", {63'h0, sawValid}, 64'd0);

        flush = 1'b1; validIn = 1'b1;
        @(negedge clk);
        flush = 1'b0; validIn = 1'b0;
        checkOutput("flush blocks accept", {62'h0, ready64, ready32}, 64'b11);

        // Reset mid-calculation takes effect without waiting for a clock edge.
        funct3 = 3'd4; aIn = 64'd1000; bIn = 64'd3; validIn = 1'b1;
        @(negedge clk);
        validIn = 1'b0;
        repeat (4) @(negedge clk);
        #2 rstN = 1'b0;
        #1;
        checkOutput("async reset rdy/vld", {60'h0, ready64, valid64, ready32, valid32}, 64'b1010);
        checkOutput("async reset res64", res64, 64'd0);
        checkOutput("async reset res32", {32'h0, res32}, 64'd0);
        @(negedge clk);
        rstN = 1'b1;

        applyStimulus(3'd4, 1'b0, 64'd1000, 64'd3, r32, r64, l32, l64);
        checkOutput("post reset res32", r32, 64'd333);
        checkOutput("post reset res64", r64, 64'd333);
        checkOutput("post reset lat64", 64'(l64), 64'd65);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
